// File: rtl/rvc_fetch_expander.sv
// rvc_fetch_expander: fetch-to-decode front end.
// Fetch words are split into 16-bit parcels held in a small circular queue.
// The head of the queue is decoded as either a compressed parcel (expanded to
// its RV32I equivalent) or the lower half of a 32-bit instruction. Complete
// instructions are moved into a registered output stage with valid/ready
// handshaking. A flush redirects the stream to a new halfword-aligned PC.
module rvc_fetch_expander #(
  parameter int          QDEPTH   = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ENABLE_C = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic [31:0] fetch_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_compressed,
  output logic        out_illegal
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  // A word (two parcels) fits only while occupancy is at most QDEPTH-2.
  localparam logic [CW-1:0] FILL_MAX = CW'(QDEPTH - 2);

  // Expand one compressed parcel. Result is {illegal, instr}; an illegal
  // parcel is returned zero-extended so decode can report it.
  function automatic logic [32:0] expand_rvc(input logic [15:0] c);
    logic [31:0] instr;
    logic        ill;
    logic [4:0]  rd_f;
    logic [4:0]  rs2_f;
    logic [4:0]  rdp;
    logic [4:0]  rs1p;
    logic [11:0] imm6_sx;
    logic [20:0] joff;
    instr   = 32'h0000_0000;
    ill     = 1'b0;
    rd_f    = c[11:7];
    rs2_f   = c[6:2];
    rdp     = {2'b01, c[4:2]};
    rs1p    = {2'b01, c[9:7]};
    imm6_sx = {{6{c[12]}}, c[12], c[6:2]};
    // Jump offset bits are scattered across the parcel; bit 0 is always 0.
    joff    = {{10{c[12]}}, c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0};
    case (c[1:0])
      2'b00: begin
        case (c[15:13])
          3'b010:  instr = {5'b00000, c[5], c[12:10], c[6], 2'b00, rs1p, 3'b010, rdp, 7'b0000011};
          3'b110:  instr = {5'b00000, c[5], c[12], rdp, rs1p, 3'b010, c[11:10], c[6], 2'b00, 7'b0100011};
          default: ill = 1'b1;
        endcase
      end
      2'b01: begin
        case (c[15:13])
          3'b000:  instr = {imm6_sx, rd_f, 3'b000, rd_f, 7'b0010011};
          3'b001:  instr = {joff[20], joff[10:1], joff[11], joff[19:12], 5'd1, 7'b1101111};
          3'b010:  instr = {imm6_sx, 5'd0, 3'b000, rd_f, 7'b0010011};
          3'b011: begin
            // rd=x2 would be C.ADDI16SP, which is not part of the supported subset.
            if (({c[12], c[6:2]} == 6'd0) || (rd_f == 5'd2)) begin
              ill = 1'b1;
            end else begin
              instr = {{14{c[12]}}, c[12], c[6:2], rd_f, 7'b0110111};
            end
          end
          3'b101:  instr = {joff[20], joff[10:1], joff[11], joff[19:12], 5'd0, 7'b1101111};
          default: ill = 1'b1;
        endcase
      end
      2'b10: begin
        case (c[15:13])
          3'b100: begin
            if (rs2_f == 5'd0) begin
              // rs1=x0 here is C.EBREAK (bit12=1) or reserved (bit12=0).
              if (rd_f == 5'd0) begin
                ill = 1'b1;
              end else if (c[12]) begin
                instr = {12'h000, rd_f, 3'b000, 5'd1, 7'b1100111};
              end else begin
                instr = {12'h000, rd_f, 3'b000, 5'd0, 7'b1100111};
              end
            end else if (c[12]) begin
              instr = {7'b0000000, rs2_f, rd_f, 3'b000, rd_f, 7'b0110011};
            end else begin
              instr = {7'b0000000, rs2_f, 5'd0, 3'b000, rd_f, 7'b0110011};
            end
          end
          default: ill = 1'b1;
        endcase
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      instr = {16'h0000, c};
    end else begin
      instr = instr;
    end
    return {ill, instr};
  endfunction

  logic [15:0]   queue_q [QDEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          discard_q, discard_d;
  logic [31:0]   head_pc_q, head_pc_d;
  logic          out_valid_q, out_valid_d;
  logic [31:0]   out_instr_q, out_instr_d;
  logic [31:0]   out_pc_q, out_pc_d;
  logic          out_c_q, out_c_d;
  logic          out_ill_q, out_ill_d;

  logic [PW-1:0] rd_ptr_nx_s;
  logic [PW-1:0] wr_ptr_nx_s;
  logic [15:0]   head_lo_s;
  logic [15:0]   head_hi_s;
  logic          head_is_c_s;
  logic          instr_ready_s;
  logic          push_s;
  logic          load_s;
  logic [1:0]    push_cnt_s;
  logic [1:0]    pop_cnt_s;
  logic [32:0]   exp_s;

  // Flush blocks acceptance so a redirected stream never mixes with old words.
  assign fetch_ready = (count_q <= FILL_MAX) && !flush;

  // Head decode and handshake qualification.
  always_comb begin
    rd_ptr_nx_s   = rd_ptr_q + PW'(1);
    wr_ptr_nx_s   = wr_ptr_q + PW'(1);
    head_lo_s     = queue_q[rd_ptr_q];
    head_hi_s     = queue_q[rd_ptr_nx_s];
    head_is_c_s   = (ENABLE_C != 0) && (head_lo_s[1:0] != 2'b11);
    exp_s         = expand_rvc(head_lo_s);
    if (head_is_c_s) begin
      instr_ready_s = (count_q != '0);
    end else begin
      instr_ready_s = (count_q >= CW'(2));
    end
    push_s = fetch_valid && fetch_ready;
    load_s = !flush && instr_ready_s && (!out_valid_q || out_ready);
    if (push_s) begin
      push_cnt_s = discard_q ? 2'd1 : 2'd2;
    end else begin
      push_cnt_s = 2'd0;
    end
    if (load_s) begin
      pop_cnt_s = head_is_c_s ? 2'd1 : 2'd2;
    end else begin
      pop_cnt_s = 2'd0;
    end
  end

  // Parcel storage write; after a misaligned redirect only the upper half is kept.
  always_ff @(posedge clk) begin
    if (push_s) begin
      if (discard_q) begin
        queue_q[wr_ptr_q] <= fetch_data[31:16];
      end else begin
        queue_q[wr_ptr_q]    <= fetch_data[15:0];
        queue_q[wr_ptr_nx_s] <= fetch_data[31:16];
      end
    end
  end

  // Next-state for queue bookkeeping, head PC and output stage.
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    discard_d   = discard_q;
    head_pc_d   = head_pc_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    out_c_d     = out_c_q;
    out_ill_d   = out_ill_q;
    if (flush) begin
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      count_d     = '0;
      discard_d   = flush_pc[1];
      head_pc_d   = flush_pc & 32'hFFFF_FFFE;
      out_valid_d = 1'b0;
    end else begin
      wr_ptr_d = wr_ptr_q + PW'(push_cnt_s);
      rd_ptr_d = rd_ptr_q + PW'(pop_cnt_s);
      count_d  = count_q + CW'(push_cnt_s) - CW'(pop_cnt_s);
      if (push_s) begin
        discard_d = 1'b0;
      end else begin
        discard_d = discard_q;
      end
      if (load_s) begin
        out_valid_d = 1'b1;
        out_pc_d    = head_pc_q;
        if (head_is_c_s) begin
          out_instr_d = exp_s[31:0];
          out_c_d     = 1'b1;
          out_ill_d   = exp_s[32];
          head_pc_d   = head_pc_q + 32'd2;
        end else begin
          out_instr_d = {head_hi_s, head_lo_s};
          out_c_d     = 1'b0;
          out_ill_d   = 1'b0;
          head_pc_d   = head_pc_q + 32'd4;
        end
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = out_valid_q;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      discard_q   <= 1'b0;
      head_pc_q   <= RESET_PC;
      out_valid_q <= 1'b0;
      out_instr_q <= 32'h0000_0000;
      out_pc_q    <= RESET_PC;
      out_c_q     <= 1'b0;
      out_ill_q   <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      discard_q   <= discard_d;
      head_pc_q   <= head_pc_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
      out_c_q     <= out_c_d;
      out_ill_q   <= out_ill_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_instr      = out_instr_q;
  assign out_pc         = out_pc_q;
  assign out_compressed = out_c_q;
  assign out_illegal    = out_ill_q;

endmodule

// File: tb/tb_rvc_fetch_expander.sv
// Scoreboard bench for rvc_fetch_expander: directed scenarios with constant
// expectations plus randomized traffic against an arithmetic reference model.
module tb_rvc_fetch_expander;

  localparam logic [31:0] RPC = 32'h0000_1000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        c;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic [31:0] flush_pc;
  logic fetch_valid, fetch_ready;
  logic [31:0] fetch_data;
  logic out_valid, out_ready;
  logic [31:0] out_instr, out_pc;
  logic out_compressed, out_illegal;

  logic nc_flush;
  logic [31:0] nc_flush_pc;
  logic nc_fetch_valid, nc_fetch_ready;
  logic [31:0] nc_fetch_data;
  logic nc_out_valid, nc_out_ready;
  logic [31:0] nc_out_instr, nc_out_pc;
  logic nc_out_compressed, nc_out_illegal;

  exp_t sb[$];
  exp_t sb_nc[$];
  logic [15:0] pq[$];
  logic [31:0] mpc;
  bit mdisc;
  bit use_model;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rvc_fetch_expander #(.QDEPTH(4), .RESET_PC(RPC), .ENABLE_C(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .flush_pc(flush_pc),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_data(fetch_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_compressed(out_compressed), .out_illegal(out_illegal));

  rvc_fetch_expander #(.QDEPTH(4), .RESET_PC(RPC), .ENABLE_C(0)) dut_nc (
    .clk(clk), .rst(rst), .flush(nc_flush), .flush_pc(nc_flush_pc),
    .fetch_valid(nc_fetch_valid), .fetch_ready(nc_fetch_ready), .fetch_data(nc_fetch_data),
    .out_valid(nc_out_valid), .out_ready(nc_out_ready), .out_instr(nc_out_instr), .out_pc(nc_out_pc),
    .out_compressed(nc_out_compressed), .out_illegal(nc_out_illegal));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int opc);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], opc[6:0]};
  endfunction
  function automatic logic [31:0] enc_s(int imm, int rs2, int rs1);
    return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_j(int off, int rd);
    return {off[20], off[10:1], off[11], off[19:12], rd[4:0], 7'h6f};
  endfunction
  function automatic logic [31:0] enc_u(int imm20, int rd);
    return {imm20[19:0], rd[4:0], 7'h37};
  endfunction
  function automatic logic [31:0] enc_r(int rs2, int rs1, int rd);
    return {7'h00, rs2[4:0], rs1[4:0], 3'b000, rd[4:0], 7'h33};
  endfunction

  // Returns {illegal, instr} computed from field values and integer immediates.
  function automatic logic [32:0] ref_expand(input logic [15:0] p);
    int q, f3, rd, rs2, rdp, rs1p, imm6, uimm, joff;
    logic [31:0] r;
    bit bad;
    q    = int'(p[1:0]);
    f3   = int'(p[15:13]);
    rd   = int'(p[11:7]);
    rs2  = int'(p[6:2]);
    rdp  = 8 + int'(p[4:2]);
    rs1p = 8 + int'(p[9:7]);
    imm6 = int'(p[6:2]) - (p[12] ? 32 : 0);
    uimm = int'(p[5]) * 64 + int'(p[12:10]) * 8 + int'(p[6]) * 4;
    joff = int'(p[5:3]) * 2 + int'(p[11]) * 16 + int'(p[2]) * 32 + int'(p[7]) * 64
         + int'(p[6]) * 128 + int'(p[10:9]) * 256 + int'(p[8]) * 1024 - (p[12] ? 2048 : 0);
    r = 32'h0;
    bad = 1'b0;
    if (q == 0 && f3 == 2) r = enc_i(uimm, rs1p, 2, rdp, 3);
    else if (q == 0 && f3 == 6) r = enc_s(uimm, rdp, rs1p);
    else if (q == 1 && f3 == 0) r = enc_i(imm6, rd, 0, rd, 19);
    else if (q == 1 && f3 == 1) r = enc_j(joff, 1);
    else if (q == 1 && f3 == 2) r = enc_i(imm6, 0, 0, rd, 19);
    else if (q == 1 && f3 == 3) begin
      if (imm6 == 0 || rd == 2) bad = 1'b1;
      else r = enc_u(imm6, rd);
    end
    else if (q == 1 && f3 == 5) r = enc_j(joff, 0);
    else if (q == 2 && f3 == 4) begin
      if (rs2 == 0) begin
        if (rd == 0) bad = 1'b1;
        else r = enc_i(0, rd, 0, p[12] ? 1 : 0, 103);
      end else begin
        r = enc_r(rs2, p[12] ? rd : 0, rd);
      end
    end
    else bad = 1'b1;
    if (bad) r = {16'h0000, p};
    return {bad, r};
  endfunction

  task automatic push_exp(input logic [31:0] i, input logic [31:0] pc, input logic c, input logic il);
    exp_t e;
    e.instr = i; e.pc = pc; e.c = c; e.ill = il;
    sb.push_back(e);
  endtask

  task automatic model_reset(input logic [31:0] pc);
    sb.delete(); pq.delete(); mpc = pc; mdisc = 1'b0;
  endtask

  task automatic model_flush(input logic [31:0] fpc);
    sb.delete(); pq.delete();
    mpc = {fpc[31:1], 1'b0};
    mdisc = fpc[1];
  endtask

  task automatic model_word(input logic [31:0] w);
    logic [15:0] p;
    logic [32:0] x;
    if (mdisc) begin
      pq.push_back(w[31:16]);
      mdisc = 1'b0;
    end else begin
      pq.push_back(w[15:0]);
      pq.push_back(w[31:16]);
    end
    while (pq.size() != 0) begin
      p = pq[0];
      if (p[1:0] != 2'b11) begin
        x = ref_expand(p);
        push_exp(x[31:0], mpc, 1'b1, x[32]);
        void'(pq.pop_front());
        mpc = mpc + 32'd2;
      end else if (pq.size() >= 2) begin
        push_exp({pq[1], pq[0]}, mpc, 1'b0, 1'b0);
        void'(pq.pop_front());
        void'(pq.pop_front());
        mpc = mpc + 32'd4;
      end else begin
        break;
      end
    end
  endtask

  // ---------------- driver helpers ----------------
  // One clock: sample the handshake at negedge, update the model after the edge.
  task automatic step(output bit acc);
    logic fl;
    logic [31:0] fpc, fd;
    @(negedge clk);
    acc = fetch_valid && fetch_ready;
    fl  = flush;
    fpc = flush_pc;
    fd  = fetch_data;
    @(posedge clk);
    #1;
    if (fl) model_flush(fpc);
    else if (acc && use_model) model_word(fd);
  endtask

  task automatic do_flush(input logic [31:0] pc);
    bit a;
    flush = 1'b1; flush_pc = pc;
    step(a);
    flush = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    bit a;
    int n;
    fetch_valid = 1'b1; fetch_data = w; a = 1'b0; n = 0;
    while (!a && n < 20) begin step(a); n++; end
    if (!a) begin
      n_checks++; n_fail++;
      $display("FAIL send_word: word %h not accepted within 20 cycles, required acceptance", w);
    end
    fetch_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    bit a;
    int n;
    fetch_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; n = 0;
    while (sb.size() != 0 && n < 64) begin step(a); n++; end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d outputs outstanding, required 0", tag, sb.size());
    end
    for (int i = 0; i < 4; i++) step(a);
  endtask

  task automatic nc_send(input logic [31:0] w);
    bit a;
    int n;
    nc_fetch_valid = 1'b1; nc_fetch_data = w; a = 1'b0; n = 0;
    while (!a && n < 20) begin
      @(negedge clk);
      a = nc_fetch_valid && nc_fetch_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!a) begin
      n_checks++; n_fail++;
      $display("FAIL nc_send: word %h not accepted, required acceptance", w);
    end
    nc_fetch_valid = 1'b0;
  endtask

  task automatic do_reset_mid();
    fetch_valid = 1'b0; flush = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 32'd0);
    chk("rst_out_pc", out_pc, RPC);
    chk("rst_out_instr", out_instr, 32'd0);
    model_reset(RPC);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_fetch_ready", fetch_ready, 32'd1);
  endtask

  // ---------------- monitors ----------------
  initial begin : mon
    exp_t e;
    bit held = 1'b0;
    logic [31:0] h_i, h_pc;
    logic h_c, h_il;
    forever begin
      @(negedge clk);
      if (held && out_valid) begin
        chk("hold_instr", out_instr, h_i);
        chk("hold_pc", out_pc, h_pc);
        chk("hold_c", out_compressed, h_c);
        chk("hold_ill", out_illegal, h_il);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_output: got instr %h pc %h, required no output", out_instr, out_pc);
        end else begin
          e = sb.pop_front();
          chk("out_instr", out_instr, e.instr);
          chk("out_pc", out_pc, e.pc);
          chk("out_compressed", out_compressed, e.c);
          chk("out_illegal", out_illegal, e.ill);
        end
      end
      held = out_valid && !out_ready;
      h_i = out_instr; h_pc = out_pc; h_c = out_compressed; h_il = out_illegal;
    end
  end

  initial begin : mon_nc
    exp_t e;
    forever begin
      @(negedge clk);
      if (nc_out_valid && nc_out_ready) begin
        if (sb_nc.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL nc_unexpected_output: got instr %h, required no output", nc_out_instr);
        end else begin
          e = sb_nc.pop_front();
          chk("nc_out_instr", nc_out_instr, e.instr);
          chk("nc_out_pc", nc_out_pc, e.pc);
          chk("nc_out_compressed", nc_out_compressed, e.c);
          chk("nc_out_illegal", nc_out_illegal, e.ill);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin : main
    bit a, saw_drop;
    exp_t e;
    int n;
    rst = 1'b1; flush = 1'b0; flush_pc = 32'h0; fetch_valid = 1'b0; fetch_data = 32'h0;
    out_ready = 1'b1; use_model = 1'b0;
    nc_flush = 1'b0; nc_flush_pc = 32'h0; nc_fetch_valid = 1'b0; nc_fetch_data = 32'h0;
    nc_out_ready = 1'b1;
    model_reset(RPC);
    #12;
    chk("reset_out_valid", out_valid, 32'd0);
    chk("reset_out_pc", out_pc, RPC);
    chk("reset_out_instr", out_instr, 32'd0);
    chk("reset_out_c", out_compressed, 32'd0);
    chk("reset_out_ill", out_illegal, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("reset_fetch_ready", fetch_ready, 32'd1);

    // ENABLE_C=0 instance: parcel pairs are always raw 32-bit instructions.
    e.instr = 32'h0050_0513; e.pc = RPC; e.c = 1'b0; e.ill = 1'b0; sb_nc.push_back(e);
    e.instr = 32'h147D_4144; e.pc = RPC + 32'd4; sb_nc.push_back(e);
    nc_send(32'h0050_0513);
    nc_send(32'h147D_4144);
    n = 0;
    while (sb_nc.size() != 0 && n < 20) begin @(posedge clk); #1; n++; end
    chk("nc_drain_outstanding", sb_nc.size(), 32'd0);

    // Aligned mix with a straddling 32-bit instruction.
    do_flush(32'h0000_0100);
    push_exp(32'h0045_2483, 32'h0000_0100, 1'b1, 1'b0);
    push_exp(32'h0050_0513, 32'h0000_0102, 1'b0, 1'b0);
    push_exp(32'hFFF4_0413, 32'h0000_0106, 1'b1, 1'b0);
    send_word(32'h0513_4144);
    send_word(32'h147D_0050);
    drain("aligned");

    // Misaligned redirect drops the lower parcel.
    do_flush(32'h0000_0202);
    push_exp(32'hFFF4_0413, 32'h0000_0202, 1'b1, 1'b0);
    send_word(32'h147D_ABCD);
    drain("misaligned");

    // All-zero parcels are illegal and do not stall.
    do_flush(32'h0000_0300);
    push_exp(32'h0000_0000, 32'h0000_0300, 1'b1, 1'b1);
    push_exp(32'h0000_0000, 32'h0000_0302, 1'b1, 1'b1);
    send_word(32'h0000_0000);
    drain("illegal");

    // Flush while a 32-bit lower half is waiting: stale half must vanish.
    do_flush(32'h0000_0500);
    push_exp(32'h0045_2483, 32'h0000_0500, 1'b1, 1'b0);
    send_word(32'h0513_4144);
    drain("pre_flush");
    do_flush(32'h0000_0600);
    push_exp(32'h0000_0013, 32'h0000_0600, 1'b1, 1'b0);
    push_exp(32'hFFF4_0413, 32'h0000_0602, 1'b1, 1'b0);
    send_word(32'h147D_0001);
    drain("post_flush");

    // Backpressure: decode stalls while fetch keeps offering words.
    use_model = 1'b1;
    do_flush(32'h0000_0400);
    out_ready = 1'b0; fetch_valid = 1'b1; saw_drop = 1'b0;
    for (int i = 0; i < 6; i++) begin
      fetch_data = $urandom;
      step(a);
      if (!a) saw_drop = 1'b1;
    end
    chk("backpressure_fetch_ready_dropped", saw_drop, 32'd1);
    drain("backpressure");

    // Randomized traffic with occasional flushes and one asynchronous reset.
    do_flush(32'h0000_0800);
    fetch_data = $urandom;
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) do_reset_mid();
      flush       = ($urandom_range(0, 63) == 0);
      flush_pc    = $urandom_range(0, 32'h0000_FFFF);
      fetch_valid = ($urandom_range(0, 4) != 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      step(a);
      if (a) fetch_data = $urandom;
    end
    flush = 1'b0;
    drain("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rvc_fetch_expander.md
Name: rvc_fetch_expander

Overview:
- Sequential front-end between instruction fetch and decode.
- Accepts word-aligned 32-bit fetch words and splits them into 16-bit parcels in a parcel queue.
- Realigns mixed 16/32-bit instruction streams and expands the supported RV32C subset to RV32I encodings.
- Presents one 32-bit instruction per handshake with its PC, a compressed flag and an illegal flag.

Parameters:
- QDEPTH, 4, parcel queue depth in 16-bit entries; power of two, minimum 4.
- RESET_PC, 32'h00000000, PC loaded on reset.
- ENABLE_C, 1, when 0 every parcel pair is a 32-bit instruction and no expansion is done.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous redirect; has priority over all other activity.
- flush_pc  input  32  new PC, sampled when flush=1; bit0 ignored.
- fetch_valid  input  1  fetch_data is valid.
- fetch_ready  output  1  block accepts the fetch word this cycle.
- fetch_data  input  32  word-aligned fetch word; [15:0] is the lower-address parcel.
- out_valid  output  1  output register holds an instruction.
- out_ready  input  1  decode consumes the instruction.
- out_instr  output  32  expanded or raw 32-bit instruction.
- out_pc  output  32  PC of out_instr.
- out_compressed  output  1  instruction came from a 16-bit parcel.
- out_illegal  output  1  unsupported or reserved compressed encoding.

Behaviour:
Reset (asynchronous, any time, including mid-operation):
- Queue is emptied and the discard flag is cleared.
- out_valid=0, out_instr=0, out_pc=RESET_PC, out_compressed=0, out_illegal=0.
- Internal head PC = RESET_PC.
- fetch_ready is combinational and equals 1 the first cycle after reset.

Fetch side:
- fetch_ready = (free entries >= 2) and !flush.
- A word is accepted when fetch_valid and fetch_ready are both 1; it pushes 2 parcels, lower half first.
- The first word after a flush with flush_pc[1]=1 pushes only its upper parcel.

Instruction formation:
- Head parcel with [1:0]!=2'b11 (and ENABLE_C=1) is a 1-parcel instruction; otherwise it needs 2 parcels.
- A 32-bit instruction straddling two fetch words waits in the queue until its upper parcel arrives.
- The output register loads when (!out_valid or out_ready) and a complete instruction is at the head.
- On load, the consumed parcels are popped and head PC advances by 2 or 4.
- Push and pop in the same cycle are allowed; occupancy is updated as count+push-pop.
- Latency: a word accepted at edge N can appear on out_valid after edge N+1.
- Sustained throughput is one instruction per cycle when the queue does not run dry.
- Outputs stay stable while out_valid=1 and out_ready=0.
- Read and write pointers wrap modulo QDEPTH.

Flush:
- At the edge: empty the queue, set out_valid=0, set head PC = {flush_pc[31:1],1'b0}, and record the discard flag = flush_pc[1].
- fetch_ready=0 during the flush cycle.
- Any word presented during the flush cycle is not accepted.

Expansion (ENABLE_C=1); rd'/rs1'/rs2' map to x8+field:
- C.LW: lw rd', uimm(rs1').
- C.SW: sw rs2', uimm(rs1').
- C.ADDI: addi rd, rd, sext(imm6).
- C.LI: addi rd, x0, sext(imm6).
- C.LUI: lui rd, sext(imm6). Illegal if imm6=0 or rd=x2.
- C.J: jal x0, sext(off12).
- C.JAL: jal x1, sext(off12).
- C.JR (rs2=0, rs1!=0): jalr x0, 0(rs1).
- C.JALR (rs2=0, rs1!=0): jalr x1, 0(rs1).
- C.MV (rs2!=0): add rd, x0, rs2.
- C.ADD (rs2!=0): add rd, rd, rs2.
- Parcel 16'h0000 and all other quadrant/funct3 combinations are illegal.
- For an illegal parcel: out_illegal=1, out_instr={16'h0,parcel}, out_compressed=1. The block does not stall.

Test Plan:
- Aligned mix, compressed first: flush_pc=0x100; words 0x05134144, 0x147D0050 -> three outputs:
  - 0x00452483 at pc 0x100, c=1.
  - 0x00500513 at pc 0x102, c=0 (straddles the two words).
  - 0xFFF40413 at pc 0x106, c=1.
- Misaligned redirect: flush_pc=0x202; word 0x147DABCD -> a single output 0xFFF40413 at pc 0x202; the lower parcel is discarded.
- Backpressure: out_ready=0 for 6 cycles while fetch_valid=1 with QDEPTH=4:
  - fetch_ready drops after the queue fills.
  - out_* are held stable throughout.
  - On release, all instructions are delivered in order with no loss or duplication.
- Illegal parcels: word 0x00000000 -> two outputs, both out_illegal=1, out_instr=0x00000000, at pc p and p+2.
- Flush and reset mid-stream:
  - flush with a pending straddled half -> the stale half is never output; the first output is at flush_pc.
  - rst asserted asynchronously mid-cycle -> out_valid=0 and out_pc=RESET_PC immediately.
- ENABLE_C=0: word 0x00500513 -> output 0x00500513 with c=0; parcels are never expanded.
